// File: rtl/lb_reg_responder.sv
// lb_reg_responder: local-bus register responder below the Ethernet bridge.
// Control / pulse / W1C registers, uptime and write counters, fixed-latency reads.
// Optional 256x32 scratch RAM at 0x100-0x1FF when LB_RESP_SCRATCH_EN is defined;
// without it that range reads 32'hBADADD00 and ignores writes.
module lb_reg_responder #(
    parameter int                        ADDR_WIDTH = 24,
    parameter int                        DATA_WIDTH = 32,
    parameter int                        READ_LAT   = 3,
    parameter logic [DATA_WIDTH-1:0]     ID_WORD    = 32'h6C627231,
    parameter logic [4*DATA_WIDTH-1:0]   CTRL_RESET = '0
) (
    input  logic                      lb_clk,
    input  logic                      reset,
    input  logic                      lb_valid,
    input  logic                      lb_rnw,
    input  logic [ADDR_WIDTH-1:0]     lb_addr,
    input  logic [DATA_WIDTH-1:0]     lb_wdata,
    input  logic                      lb_renable,
    output logic [DATA_WIDTH-1:0]     lb_rdata,
    input  logic [DATA_WIDTH-1:0]     status_in,
    output logic [4*DATA_WIDTH-1:0]   ctrl_out,
    output logic [DATA_WIDTH-1:0]     pulse_out
);

    localparam int DW = DATA_WIDTH;
    localparam logic [DW-1:0] BAD_WORD = 32'hBADADD00;

    typedef enum logic [2:0] {
        SEL_ID, SEL_UP, SEL_SNAP, SEL_STKY, SEL_CTRL, SEL_ZERO, SEL_RAM, SEL_BAD
    } sel_e;

    logic wr_ev, rd_ev;
    logic hit_id, hit_up, hit_wcnt, hit_stky, hit_stat, hit_ctrl, hit_pulse;
    logic wcnt_clr;

    logic [DW-1:0]         uptime_q, uptime_d;
    logic [DW-1:0]         wcnt_q, wcnt_d;
    logic [DW-1:0]         sticky_q, sticky_d;
    logic [3:0][DW-1:0]    ctrl_q, ctrl_d;
    logic [DW-1:0]         pulse_q, pulse_d;

    // Stage 1: decoded select plus a snapshot of values that must be taken on the request edge
    sel_e                  sel1_q, sel1_d;
    logic [DW-1:0]         snap1_q, snap1_d;
    logic [1:0]            cidx1_q, cidx1_d;

    // Valid chain covers stages 1..READ_LAT-1; data stages are 2..READ_LAT
    logic [READ_LAT-1:1]       rd_vld_q, rd_vld_d;
    logic [READ_LAT:2][DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0]             rd_mux;

`ifdef LB_RESP_SCRATCH_EN
    logic          hit_ram;
    logic [7:0]    ram_idx1_q, ram_idx1_d;
    logic [DW-1:0] ram_mem [0:255];
`endif

    // Address decode and bus event qualification; a transaction during reset is dropped
    always_comb begin
        wr_ev     = lb_valid & ~lb_rnw & ~reset;
        rd_ev     = lb_valid &  lb_rnw & ~reset;
        hit_id    = (lb_addr == ADDR_WIDTH'(32'h000));
        hit_up    = (lb_addr == ADDR_WIDTH'(32'h001));
        hit_wcnt  = (lb_addr == ADDR_WIDTH'(32'h002));
        hit_stky  = (lb_addr == ADDR_WIDTH'(32'h003));
        hit_stat  = (lb_addr == ADDR_WIDTH'(32'h004));
        hit_ctrl  = (lb_addr[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(32'h2));
        hit_pulse = (lb_addr == ADDR_WIDTH'(32'h010));
`ifdef LB_RESP_SCRATCH_EN
        hit_ram   = (lb_addr[ADDR_WIDTH-1:8] == (ADDR_WIDTH-8)'(32'h1));
`endif
        wcnt_clr  = rd_ev & hit_wcnt & lb_renable;
    end

    // Next state of the register bank and counters
    always_comb begin
        uptime_d = uptime_q + 1'b1;
        wcnt_d   = (wcnt_clr ? '0 : wcnt_q) + {{(DW-1){1'b0}}, wr_ev};
        // status_in is OR-ed in last so a set beats a simultaneous W1C
        sticky_d = (sticky_q & ~((wr_ev & hit_stky) ? lb_wdata : '0)) | status_in;
        ctrl_d   = ctrl_q;
        if (wr_ev && hit_ctrl) begin
            ctrl_d[lb_addr[1:0]] = lb_wdata;
        end
        pulse_d  = (wr_ev & hit_pulse) ? lb_wdata : '0;
    end

    // Read stage 1 next state: decode to a compact select
    always_comb begin
        sel1_d = SEL_BAD;
        if (hit_id)         sel1_d = SEL_ID;
        else if (hit_up)    sel1_d = SEL_UP;
        else if (hit_wcnt)  sel1_d = SEL_SNAP;
        else if (hit_stky)  sel1_d = SEL_STKY;
        else if (hit_stat)  sel1_d = SEL_SNAP;
        else if (hit_ctrl)  sel1_d = SEL_CTRL;
        else if (hit_pulse) sel1_d = SEL_ZERO;
`ifdef LB_RESP_SCRATCH_EN
        else if (hit_ram)   sel1_d = SEL_RAM;
        ram_idx1_d = lb_addr[7:0];
`endif
        // Write counter is captured before a clear-on-read; status is the live value at request
        snap1_d = hit_wcnt ? wcnt_q : status_in;
        cidx1_d = lb_addr[1:0];
    end

    // Read stage 2 mux, including the scratch RAM read from the registered address
    always_comb begin
        case (sel1_q)
            SEL_ID:   rd_mux = ID_WORD;
            SEL_UP:   rd_mux = uptime_q;
            SEL_SNAP: rd_mux = snap1_q;
            SEL_STKY: rd_mux = sticky_q;
            SEL_CTRL: rd_mux = ctrl_q[cidx1_q];
            SEL_ZERO: rd_mux = '0;
`ifdef LB_RESP_SCRATCH_EN
            SEL_RAM:  rd_mux = ram_mem[ram_idx1_q];
`endif
            default:  rd_mux = BAD_WORD;
        endcase
    end

    // Read pipeline advance; each data stage only loads when a valid read reaches it
    always_comb begin
        rd_vld_d    = rd_vld_q;
        rd_vld_d[1] = rd_ev;
        for (int k = 2; k <= READ_LAT - 1; k++) begin
            rd_vld_d[k] = rd_vld_q[k-1];
        end
        rd_data_d = rd_data_q;
        if (rd_vld_q[1]) begin
            rd_data_d[2] = rd_mux;
        end
        for (int k = 3; k <= READ_LAT; k++) begin
            if (rd_vld_q[k-1]) begin
                rd_data_d[k] = rd_data_q[k-1];
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge lb_clk) begin
        if (reset) begin
            uptime_q  <= '0;
            wcnt_q    <= '0;
            sticky_q  <= '0;
            ctrl_q    <= CTRL_RESET;
            pulse_q   <= '0;
            sel1_q    <= SEL_BAD;
            snap1_q   <= '0;
            cidx1_q   <= '0;
            rd_vld_q  <= '0;
            rd_data_q <= '0;
        end else begin
            uptime_q  <= uptime_d;
            wcnt_q    <= wcnt_d;
            sticky_q  <= sticky_d;
            ctrl_q    <= ctrl_d;
            pulse_q   <= pulse_d;
            sel1_q    <= sel1_d;
            snap1_q   <= snap1_d;
            cidx1_q   <= cidx1_d;
            rd_vld_q  <= rd_vld_d;
            rd_data_q <= rd_data_d;
        end
    end

`ifdef LB_RESP_SCRATCH_EN
    // Scratch RAM: no reset so it maps onto block RAM; index is only used during reads
    always_ff @(posedge lb_clk) begin
        ram_idx1_q <= ram_idx1_d;
        if (wr_ev && hit_ram) begin
            ram_mem[lb_addr[7:0]] <= lb_wdata;
        end
    end
`endif

    assign lb_rdata  = rd_data_q[READ_LAT];
    assign ctrl_out  = ctrl_q;
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_lb_reg_responder.sv
// Directed bench for lb_reg_responder with a read scoreboard.
module tb_lb_reg_responder;

    localparam int          READ_LAT = 3;
    localparam logic [31:0] ID_W     = 32'h6C627231;
    localparam logic [31:0] BAD_W    = 32'hBADADD00;
`ifdef LB_RESP_SCRATCH_EN
    localparam logic [31:0] SCR_HI   = 32'h12345678;
    localparam logic [31:0] SCR_LO   = 32'h000000A5;
`else
    localparam logic [31:0] SCR_HI   = BAD_W;
    localparam logic [31:0] SCR_LO   = BAD_W;
`endif

    logic         lb_clk = 1'b0;
    logic         reset = 1'b1;
    logic         lb_valid = 1'b0;
    logic         lb_rnw = 1'b0;
    logic         lb_renable = 1'b0;
    logic [23:0]  lb_addr = '0;
    logic [31:0]  lb_wdata = '0;
    logic [31:0]  status_in = '0;
    logic [31:0]  lb_rdata;
    logic [31:0]  pulse_out;
    logic [127:0] ctrl_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wcnt_model = 0;
    logic [31:0] up0, up1;

    typedef struct {
        logic [31:0] exp;
        int          due;
        string       tag;
    } exp_t;
    exp_t sb[$];

    lb_reg_responder #(.READ_LAT(READ_LAT)) dut (
        .lb_clk     (lb_clk),
        .reset      (reset),
        .lb_valid   (lb_valid),
        .lb_rnw     (lb_rnw),
        .lb_addr    (lb_addr),
        .lb_wdata   (lb_wdata),
        .lb_renable (lb_renable),
        .lb_rdata   (lb_rdata),
        .status_in  (status_in),
        .ctrl_out   (ctrl_out),
        .pulse_out  (pulse_out)
    );

    always #5 lb_clk = ~lb_clk;
    always @(posedge lb_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop the oldest expected read when its completion cycle arrives
    always @(negedge lb_clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            chk(sb[0].tag, 128'(lb_rdata), 128'(sb[0].exp));
            void'(sb.pop_front());
        end
    end

    task automatic wr(input logic [23:0] a, input logic [31:0] d);
        lb_valid = 1'b1; lb_rnw = 1'b0; lb_addr = a; lb_wdata = d;
        @(negedge lb_clk);
        lb_valid = 1'b0;
        if (!reset) wcnt_model++;
    endtask

    task automatic raw_rd(input logic [23:0] a, input logic ren);
        lb_valid = 1'b1; lb_rnw = 1'b1; lb_addr = a; lb_renable = ren;
        @(negedge lb_clk);
        lb_valid = 1'b0; lb_renable = 1'b0;
    endtask

    task automatic rd(input logic [23:0] a, input logic [31:0] e, input string tag, input logic ren);
        exp_t x;
        x.exp = e; x.due = cyc + READ_LAT; x.tag = tag;
        sb.push_back(x);
        raw_rd(a, ren);
        if (ren && a == 24'h2) wcnt_model = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge lb_clk);
        end
        chk("drain_timeout", 128'(sb.size()), 128'(0));
        sb.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge lb_clk);
        chk("rst_ctrl_out", ctrl_out, 128'h0);
        chk("rst_rdata", 128'(lb_rdata), 128'h0);
        chk("rst_pulse", 128'(pulse_out), 128'h0);
        reset = 1'b0;

        // ID read with exact latency
        rd(24'h000, ID_W, "id_read", 1'b0);
        @(negedge lb_clk);
        chk("id_not_early", 128'(lb_rdata), 128'h0);
        drain();

        // Control register write then read on the next cycle
        wr(24'h009, 32'hA5A50001);
        chk("ctrl1_out", 128'(ctrl_out[63:32]), 128'(32'hA5A50001));
        rd(24'h009, 32'hA5A50001, "ctrl1_raw", 1'b0);
        wr(24'h00B, 32'h0BADF00D);
        rd(24'h00B, 32'h0BADF00D, "ctrl3_rd", 1'b0);
        rd(24'h008, 32'h0, "ctrl0_rd", 1'b0);
        drain();
        chk("ctrl_out_all", ctrl_out, {32'h0BADF00D, 32'h0, 32'hA5A50001, 32'h0});

        // Sticky status
        status_in = 32'h10;
        @(negedge lb_clk);
        status_in = 32'h0;
        rd(24'h003, 32'h10, "sticky_set", 1'b0);
        status_in = 32'h10;
        wr(24'h003, 32'h10);
        status_in = 32'h0;
        rd(24'h003, 32'h10, "sticky_set_wins", 1'b0);
        wr(24'h003, 32'h10);
        rd(24'h003, 32'h0, "sticky_cleared", 1'b0);
        status_in = 32'hDEAD0000;
        rd(24'h004, 32'hDEAD0000, "status_live0", 1'b0);
        status_in = 32'h00000001;
        rd(24'h004, 32'h00000001, "status_live1", 1'b0);
        status_in = 32'h0;
        rd(24'h003, 32'hDEAD0001, "sticky_multi", 1'b0);
        drain();

        // Write counter, unmapped addresses, RO writes
        rd(24'h002, 32'(wcnt_model), "wcnt_first", 1'b1);
        for (int i = 0; i < 5; i++) wr(24'h0FF, 32'(i));
        rd(24'h0FF, BAD_W, "unmapped_rd", 1'b0);
        rd(24'h002, 32'd5, "wcnt_five", 1'b1);
        rd(24'h002, 32'd0, "wcnt_after_clear", 1'b1);
        wr(24'h000, 32'hFFFFFFFF);
        rd(24'h000, ID_W, "id_ro", 1'b0);
        rd(24'h002, 32'(wcnt_model), "wcnt_ro_write", 1'b0);
        rd(24'h002, 32'(wcnt_model), "wcnt_no_clear", 1'b1);
        drain();

        // Pulse register
        chk("pulse_idle", 128'(pulse_out), 128'h0);
        wr(24'h010, 32'h00000081);
        chk("pulse_on", 128'(pulse_out), 128'h81);
        @(negedge lb_clk);
        chk("pulse_off", 128'(pulse_out), 128'h0);
        rd(24'h010, 32'h0, "pulse_rd_zero", 1'b0);
        drain();

        // Uptime advances one per cycle: reads issued five cycles apart
        raw_rd(24'h001, 1'b0);
        repeat (READ_LAT - 1) @(negedge lb_clk);
        up0 = lb_rdata;
        repeat (2) @(negedge lb_clk);
        raw_rd(24'h001, 1'b0);
        repeat (READ_LAT - 1) @(negedge lb_clk);
        up1 = lb_rdata;
        chk("uptime_delta", 128'(up1 - up0), 128'd5);

        // Scratch range
        wr(24'h1FF, 32'h12345678);
        rd(24'h1FF, SCR_HI, "scratch_hi", 1'b0);
        wr(24'h100, 32'h000000A5);
        rd(24'h100, SCR_LO, "scratch_lo", 1'b0);
        rd(24'h200, BAD_W, "past_scratch", 1'b0);
        drain();

        // Reset during a pending read, and a write coincident with reset
        rd(24'h000, ID_W, "id_before_rst", 1'b0);
        drain();
        wr(24'h008, 32'h0000CAFE);
        raw_rd(24'h008, 1'b0);
        reset = 1'b1;
        wr(24'h009, 32'h11111111);
        chk("rst_mid_rdata", 128'(lb_rdata), 128'h0);
        chk("rst_mid_ctrl", ctrl_out, 128'h0);
        reset = 1'b0;
        for (int i = 0; i < READ_LAT + 1; i++) begin
            @(negedge lb_clk);
            chk("rst_no_stale", 128'(lb_rdata), 128'h0);
        end
        rd(24'h009, 32'h0, "rst_write_ignored", 1'b0);
        rd(24'h002, 32'h0, "rst_wcnt", 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
